// File: rtl/red_pitaya_iq_boxcar_decimator_pkg.sv
// Shared definitions for the IQ boxcar decimator.
//   - Default widths (INBITS, OUTBITS, MAXLOG2N, LOGBITS) and accumulator width.
//   - clamp_log2n : limits a requested block-length exponent to the supported maximum.
//   - round_offset: bias added before an arithmetic right shift of s bits so the
//                   result rounds half toward zero (also used by the demodulator).
package red_pitaya_iq_boxcar_decimator_pkg;

  localparam int DEF_INBITS   = 18;
  localparam int DEF_OUTBITS  = 20;
  localparam int DEF_MAXLOG2N = 16;
  localparam int DEF_LOGBITS  = 5;
  localparam int DEF_ACCBITS  = DEF_INBITS + DEF_MAXLOG2N;

  function automatic int clamp_log2n(input int req, input int maxlog2n);
    return (req > maxlog2n) ? maxlog2n : req;
  endfunction

  // Negative values get the full half so ties move up toward zero; non-negative
  // values get one less than half so ties stay down toward zero. Requires s >= 1.
  function automatic longint round_offset(input int s, input bit neg);
    longint half;
    half = longint'(1) <<< (s - 1);
    return neg ? half : half - 1;
  endfunction

endpackage

// File: rtl/red_pitaya_iq_boxcar_channel.sv
// One quadrature of the boxcar decimator: accumulator, block-sum register and
// the scaled/rounded output register. Block control comes from the top level.
//   clk, rstn : clock, asynchronous active-low reset
//   sample    : signed input sample
//   take      : sample is accepted on this edge
//   last      : accepted sample closes the block
//   restart   : abort the partial block (accumulator cleared)
//   vld_p1    : block sum register holds a fresh result
//   ln_p1     : block-length exponent that belongs to the held sum
//   result    : scaled block mean, holds between updates
module red_pitaya_iq_boxcar_channel
  import red_pitaya_iq_boxcar_decimator_pkg::*;
#(
  parameter int INBITS   = DEF_INBITS,
  parameter int OUTBITS  = DEF_OUTBITS,
  parameter int MAXLOG2N = DEF_MAXLOG2N,
  parameter int LOGBITS  = DEF_LOGBITS
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic signed [INBITS-1:0]  sample,
  input  logic                      take,
  input  logic                      last,
  input  logic                      restart,
  input  logic                      vld_p1,
  input  logic [LOGBITS-1:0]        ln_p1,
  output logic signed [OUTBITS-1:0] result
);

  localparam int ACCBITS = INBITS + MAXLOG2N;
  localparam int FRAC    = OUTBITS - INBITS;
  // Working width for scaling: room for the left shift and the rounding bias.
  localparam int WW      = ((ACCBITS > OUTBITS) ? ACCBITS : OUTBITS) + 1;

  logic signed [ACCBITS-1:0] acc_p0;
  logic signed [ACCBITS-1:0] sum_p1;
  logic signed [ACCBITS-1:0] next_sum;

  // The sum of 2^ln samples scaled to OUTBITS: a left shift when the averaging
  // gain fits in the extra fractional bits, otherwise a rounded right shift.
  function automatic logic signed [OUTBITS-1:0] scale(
    input logic signed [ACCBITS-1:0] sum,
    input logic [LOGBITS-1:0]        ln
  );
    logic signed [WW-1:0] wide;
    int                   l;
    l    = int'(ln);
    wide = WW'(sum);
    if (l <= FRAC) begin
      wide = wide <<< (FRAC - l);
    end else begin
      wide = wide + WW'(round_offset(l - FRAC, sum[ACCBITS-1]));
      wide = wide >>> (l - FRAC);
    end
    return wide[OUTBITS-1:0];
  endfunction

  assign next_sum = acc_p0 + ACCBITS'(sample);

  // Stage p0 -> p1: integrate, dump the completed block into sum_p1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_p0 <= '0;
      sum_p1 <= '0;
    end else if (restart) begin
      acc_p0 <= '0;
    end else if (take) begin
      if (last) begin
        sum_p1 <= next_sum;
        acc_p0 <= '0;
      end else begin
        acc_p0 <= next_sum;
      end
    end
  end

  // Stage p1 -> output: scale and round
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result <= '0;
    end else if (vld_p1) begin
      result <= scale(sum_p1, ln_p1);
    end
  end

endmodule

// File: rtl/red_pitaya_iq_boxcar_decimator.sv
// Boxcar decimator for the two IQ demodulator quadratures. Integrates 2^log2n
// accepted samples per channel and emits the block mean with a one-cycle strobe.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   signal1_i, signal2_i : signed quadratures (INBITS)
//   enable_i             : sample qualifier
//   restart_i            : synchronous abort of the current block
//   log2n_i              : requested block-length exponent (clamped to MAXLOG2N)
//   signal1_o, signal2_o : scaled block results (OUTBITS), hold between strobes
//   valid_o              : one-cycle strobe for new results
module red_pitaya_iq_boxcar_decimator
  import red_pitaya_iq_boxcar_decimator_pkg::*;
#(
  parameter int INBITS   = DEF_INBITS,
  parameter int OUTBITS  = DEF_OUTBITS,
  parameter int MAXLOG2N = DEF_MAXLOG2N,
  parameter int LOGBITS  = DEF_LOGBITS
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic signed [INBITS-1:0]  signal1_i,
  input  logic signed [INBITS-1:0]  signal2_i,
  input  logic                      enable_i,
  input  logic                      restart_i,
  input  logic [LOGBITS-1:0]        log2n_i,
  output logic signed [OUTBITS-1:0] signal1_o,
  output logic signed [OUTBITS-1:0] signal2_o,
  output logic                      valid_o
);

  logic [MAXLOG2N-1:0] cnt;
  logic [MAXLOG2N:0]   len_m1;
  logic [LOGBITS-1:0]  ln;
  logic [LOGBITS-1:0]  ln_req;
  logic [LOGBITS-1:0]  ln_eff;
  logic [LOGBITS-1:0]  ln_p1;
  logic                take;
  logic                last;
  logic                vld_p1;

  assign ln_req = LOGBITS'(clamp_log2n(int'(log2n_i), MAXLOG2N));
  // At a block boundary (cnt==0) the new request applies to this very sample;
  // inside a block the shadow copy is frozen.
  assign ln_eff = (cnt == '0) ? ln_req : ln;
  assign len_m1 = ((MAXLOG2N + 1)'(1) << ln_eff) - (MAXLOG2N + 1)'(1);
  assign take   = enable_i & ~restart_i;
  assign last   = take && ({1'b0, cnt} == len_m1);

  // Stage p0 -> p1: block counter, shadow length, result valid
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt     <= '0;
      ln      <= '0;
      ln_p1   <= '0;
      vld_p1  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      vld_p1  <= last;
      valid_o <= vld_p1;
      // ln travels with the sum so a later length change cannot touch it.
      if (last) begin
        ln_p1 <= ln_eff;
      end
      if (restart_i) begin
        cnt <= '0;
        ln  <= ln_req;
      end else begin
        ln <= ln_eff;
        if (take) begin
          cnt <= last ? '0 : cnt + 1'b1;
        end
      end
    end
  end

  red_pitaya_iq_boxcar_channel #(
    .INBITS   (INBITS),
    .OUTBITS  (OUTBITS),
    .MAXLOG2N (MAXLOG2N),
    .LOGBITS  (LOGBITS)
  ) u_ch1 (
    .clk     (clk_i),
    .rstn    (rstn_i),
    .sample  (signal1_i),
    .take    (take),
    .last    (last),
    .restart (restart_i),
    .vld_p1  (vld_p1),
    .ln_p1   (ln_p1),
    .result  (signal1_o)
  );

  red_pitaya_iq_boxcar_channel #(
    .INBITS   (INBITS),
    .OUTBITS  (OUTBITS),
    .MAXLOG2N (MAXLOG2N),
    .LOGBITS  (LOGBITS)
  ) u_ch2 (
    .clk     (clk_i),
    .rstn    (rstn_i),
    .sample  (signal2_i),
    .take    (take),
    .last    (last),
    .restart (restart_i),
    .vld_p1  (vld_p1),
    .ln_p1   (ln_p1),
    .result  (signal2_o)
  );

endmodule

// File: tb/tb_red_pitaya_iq_boxcar_decimator.sv
// Directed testbench for red_pitaya_iq_boxcar_decimator (INBITS=18, OUTBITS=20).
module tb_red_pitaya_iq_boxcar_decimator;

  localparam int INBITS   = 18;
  localparam int OUTBITS  = 20;
  localparam int MAXLOG2N = 16;
  localparam int LOGBITS  = 5;

  logic                      clk = 1'b0;
  logic                      rstn_i;
  logic signed [INBITS-1:0]  signal1_i;
  logic signed [INBITS-1:0]  signal2_i;
  logic                      enable_i;
  logic                      restart_i;
  logic [LOGBITS-1:0]        log2n_i;
  logic signed [OUTBITS-1:0] signal1_o;
  logic signed [OUTBITS-1:0] signal2_o;
  logic                      valid_o;

  int errors  = 0;
  int checks  = 0;
  int tick_no = 0;
  int vq1[$];
  int vq2[$];
  int vt[$];

  always #5 clk = ~clk;

  red_pitaya_iq_boxcar_decimator #(
    .INBITS   (INBITS),
    .OUTBITS  (OUTBITS),
    .MAXLOG2N (MAXLOG2N),
    .LOGBITS  (LOGBITS)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .signal1_i (signal1_i),
    .signal2_i (signal2_i),
    .enable_i  (enable_i),
    .restart_i (restart_i),
    .log2n_i   (log2n_i),
    .signal1_o (signal1_o),
    .signal2_o (signal2_o),
    .valid_o   (valid_o)
  );

  // Advance one edge, sample 1 time unit later, log any valid strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (valid_o === 1'b1) begin
      vq1.push_back(int'(signal1_o));
      vq2.push_back(int'(signal2_o));
      vt.push_back(tick_no);
    end
  endtask

  task automatic clear_log();
    vq1.delete();
    vq2.delete();
    vt.delete();
  endtask

  task automatic feed(input int a, input int b);
    signal1_i = INBITS'(a);
    signal2_i = INBITS'(b);
    enable_i  = 1'b1;
    restart_i = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    enable_i  = 1'b0;
    restart_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999999;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (signal1_o !== '0) begin errors++; $display("FAIL reset_sig1: got %0d expected 0", signal1_o); end
    checks++;
    if (signal2_o !== '0) begin errors++; $display("FAIL reset_sig2: got %0d expected 0", signal2_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    idle(2);
    rstn_i = 1'b1;
    idle(2);
  endtask

  task automatic test_throughput();
    log2n_i = 5'd0;
    idle(1);
    feed(100, -5);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL thru_first_edge: got %b expected 0", valid_o); end
    feed(100, -5);
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL thru_valid_start: got %b expected 1", valid_o); end
    checks++;
    if (int'(signal1_o) !== 400) begin errors++; $display("FAIL thru_sig1: got %0d expected 400", signal1_o); end
    checks++;
    if (int'(signal2_o) !== -20) begin errors++; $display("FAIL thru_sig2: got %0d expected -20", signal2_o); end
    for (int i = 0; i < 4; i++) begin
      feed(100, -5);
      checks++;
      if (valid_o !== 1'b1) begin errors++; $display("FAIL thru_valid_cont%0d: got %b expected 1", i, valid_o); end
    end
    idle(2);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL thru_valid_drop: got %b expected 0", valid_o); end
    checks++;
    if (int'(signal1_o) !== 400) begin errors++; $display("FAIL thru_hold: got %0d expected 400", signal1_o); end
  endtask

  task automatic test_block_len();
    log2n_i = 5'd2;
    idle(1);
    clear_log();
    for (int i = 1; i <= 4; i++) feed(i, -i);
    idle(2);
    checks++;
    if (vq1.size() !== 1) begin errors++; $display("FAIL blk_count: got %0d expected 1", vq1.size()); end
    checks++;
    if (qget(vq1, 0) !== 10) begin errors++; $display("FAIL blk_sig1: got %0d expected 10", qget(vq1, 0)); end
    checks++;
    if (qget(vq2, 0) !== -10) begin errors++; $display("FAIL blk_sig2: got %0d expected -10", qget(vq2, 0)); end
    clear_log();
    for (int i = 0; i < 8; i++) feed(5, 3);
    idle(2);
    checks++;
    if (vq1.size() !== 2) begin errors++; $display("FAIL blk2_count: got %0d expected 2", vq1.size()); end
    checks++;
    if (qget(vq1, 1) !== 20 || qget(vq2, 1) !== 12) begin
      errors++; $display("FAIL blk2_vals: got %0d/%0d expected 20/12", qget(vq1, 1), qget(vq2, 1));
    end
    checks++;
    if (qget(vt, 1) - qget(vt, 0) !== 4) begin
      errors++; $display("FAIL blk2_spacing: got %0d expected 4", qget(vt, 1) - qget(vt, 0));
    end
  endtask

  task automatic test_rounding();
    int sums[5] = '{2, -2, 6, -6, 7};
    int expv[5] = '{0, 0, 1, -1, 2};
    log2n_i = 5'd4;
    idle(1);
    clear_log();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 16; j++) feed((j == 0) ? sums[k] : 0, (j == 0) ? -sums[k] : 0);
    end
    idle(2);
    checks++;
    if (vq1.size() !== 5) begin errors++; $display("FAIL rnd_count: got %0d expected 5", vq1.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (qget(vq1, k) !== expv[k]) begin
        errors++; $display("FAIL rnd_sig1_sum%0d: got %0d expected %0d", sums[k], qget(vq1, k), expv[k]);
      end
      checks++;
      if (qget(vq2, k) !== -expv[k]) begin
        errors++; $display("FAIL rnd_sig2_sum%0d: got %0d expected %0d", -sums[k], qget(vq2, k), -expv[k]);
      end
    end
  endtask

  // log2n_i=31 must be clamped to 16, so this is also the full-length extremes block.
  task automatic test_extremes_clamp();
    int start;
    log2n_i = 5'd31;
    idle(1);
    clear_log();
    start = tick_no;
    for (int i = 0; i < 65536; i++) feed(-131072, 131071);
    idle(2);
    checks++;
    if (vq1.size() !== 1) begin errors++; $display("FAIL ext_count: got %0d expected 1", vq1.size()); end
    checks++;
    if (qget(vq1, 0) !== -524288) begin errors++; $display("FAIL ext_neg: got %0d expected -524288", qget(vq1, 0)); end
    checks++;
    if (qget(vq2, 0) !== 524284) begin errors++; $display("FAIL ext_pos: got %0d expected 524284", qget(vq2, 0)); end
    checks++;
    if (qget(vt, 0) !== start + 65537) begin
      errors++; $display("FAIL ext_latency: got %0d expected %0d", qget(vt, 0), start + 65537);
    end
  endtask

  task automatic test_enable_gaps();
    int t8 = 0;
    log2n_i = 5'd3;
    idle(1);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      feed(3, -3);
      if (i == 7) t8 = tick_no;
      signal1_i = INBITS'(50000);
      signal2_i = INBITS'(-50000);
      idle(1);
    end
    idle(2);
    checks++;
    if (vq1.size() !== 1) begin errors++; $display("FAIL gap_count: got %0d expected 1", vq1.size()); end
    checks++;
    if (qget(vq1, 0) !== 12 || qget(vq2, 0) !== -12) begin
      errors++; $display("FAIL gap_vals: got %0d/%0d expected 12/-12", qget(vq1, 0), qget(vq2, 0));
    end
    checks++;
    if (qget(vt, 0) !== t8 + 1) begin errors++; $display("FAIL gap_tick: got %0d expected %0d", qget(vt, 0), t8 + 1); end
  endtask

  task automatic test_log2n_change();
    log2n_i = 5'd3;
    idle(1);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) log2n_i = 5'd1;
      feed(1, 2);
    end
    for (int i = 0; i < 2; i++) feed(5, 6);
    idle(2);
    checks++;
    if (vq1.size() !== 2) begin errors++; $display("FAIL lnchg_count: got %0d expected 2", vq1.size()); end
    checks++;
    if (qget(vq1, 0) !== 4 || qget(vq2, 0) !== 8) begin
      errors++; $display("FAIL lnchg_blk8: got %0d/%0d expected 4/8", qget(vq1, 0), qget(vq2, 0));
    end
    checks++;
    if (qget(vq1, 1) !== 20 || qget(vq2, 1) !== 24) begin
      errors++; $display("FAIL lnchg_blk2: got %0d/%0d expected 20/24", qget(vq1, 1), qget(vq2, 1));
    end
    checks++;
    if (qget(vt, 1) - qget(vt, 0) !== 2) begin
      errors++; $display("FAIL lnchg_spacing: got %0d expected 2", qget(vt, 1) - qget(vt, 0));
    end
  endtask

  task automatic test_restart();
    int r;
    log2n_i = 5'd3;
    idle(1);
    clear_log();
    for (int i = 0; i < 5; i++) feed(7, 7);
    signal1_i = INBITS'(100);
    signal2_i = INBITS'(100);
    enable_i  = 1'b1;
    restart_i = 1'b1;
    tick();
    r = tick_no;
    for (int i = 0; i < 8; i++) feed(1, -1);
    idle(2);
    checks++;
    if (vq1.size() !== 1) begin errors++; $display("FAIL rst_blk_count: got %0d expected 1", vq1.size()); end
    checks++;
    if (qget(vq1, 0) !== 4 || qget(vq2, 0) !== -4) begin
      errors++; $display("FAIL rst_blk_vals: got %0d/%0d expected 4/-4", qget(vq1, 0), qget(vq2, 0));
    end
    checks++;
    if (qget(vt, 0) !== r + 9) begin errors++; $display("FAIL rst_blk_tick: got %0d expected %0d", qget(vt, 0), r + 9); end
  endtask

  task automatic test_async_reset();
    log2n_i = 5'd2;
    idle(1);
    for (int i = 0; i < 4; i++) feed(1, 1);
    feed(9, 9);
    checks++;
    if (valid_o !== 1'b1 || int'(signal1_o) !== 4) begin
      errors++; $display("FAIL arst_pre: got %b/%0d expected 1/4", valid_o, signal1_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", valid_o); end
    checks++;
    if (signal1_o !== '0 || signal2_o !== '0) begin
      errors++; $display("FAIL arst_outs: got %0d/%0d expected 0/0", signal1_o, signal2_o);
    end
    #2 rstn_i = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) feed(1, 1);
    idle(2);
    checks++;
    if (vq1.size() !== 0) begin errors++; $display("FAIL arst_partial_lost: got %0d expected 0", vq1.size()); end
    feed(1, 1);
    idle(2);
    checks++;
    if (vq1.size() !== 1 || qget(vq1, 0) !== 4) begin
      errors++; $display("FAIL arst_full_block: got %0d pulses val %0d expected 1 val 4", vq1.size(), qget(vq1, 0));
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn_i    = 1'b0;
    signal1_i = '0;
    signal2_i = '0;
    enable_i  = 1'b0;
    restart_i = 1'b0;
    log2n_i   = '0;
    test_reset();
    test_throughput();
    test_block_len();
    test_rounding();
    test_enable_gaps();
    test_log2n_change();
    test_restart();
    test_extremes_clamp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
